// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg
//   Shared types and constants for the two-requester cache arbiter.
//   - arb_state_e : arbiter FSM encoding (2'b11 is never entered normally)
//   - GNT_I/GNT_D : grant / last-grant encoding, also the bit index of each
//                   requester inside the req/gnt vectors of arb_rr2
//   - arb_rsp_t   : response routed back to whichever port owns the cache
package cache_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_BUSY_I = 2'b01,
        ARB_BUSY_D = 2'b10,
        ARB_BAD    = 2'b11
    } arb_state_e;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    typedef struct packed {
        logic              done;
        logic              hit;
        logic              err;
        logic [DATA_W-1:0] data;
    } arb_rsp_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if
//   Bundles the fetch port (i_*), the memory-stage port (d_*) and the cache
//   controller port (c_*) of the arbiter.
//   - slave  : the arbiter's view (consumes requests and cache responses)
//   - master : the environment's view (pipeline stages plus cache controller)
interface cache_arbiter_if;
    import cache_arb_pkg::*;

    // Instruction-fetch port
    logic              i_rd;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_data_out;
    logic              i_done;
    logic              i_stall;
    logic              i_hit;
    logic              i_err;

    // Data-memory port
    logic              d_rd;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_data_in;
    logic [DATA_W-1:0] d_data_out;
    logic              d_done;
    logic              d_stall;
    logic              d_hit;
    logic              d_err;

    // Cache controller port
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data_in;
    logic              c_rd;
    logic              c_wr;
    logic [DATA_W-1:0] c_data_out;
    logic              c_done;
    logic              c_stall;
    logic              c_hit;
    logic              c_err;

    modport slave (
        input  i_rd, i_addr,
        output i_data_out, i_done, i_stall, i_hit, i_err,
        input  d_rd, d_wr, d_addr, d_data_in,
        output d_data_out, d_done, d_stall, d_hit, d_err,
        output c_addr, c_data_in, c_rd, c_wr,
        input  c_data_out, c_done, c_stall, c_hit, c_err
    );

    modport master (
        output i_rd, i_addr,
        input  i_data_out, i_done, i_stall, i_hit, i_err,
        output d_rd, d_wr, d_addr, d_data_in,
        input  d_data_out, d_done, d_stall, d_hit, d_err,
        input  c_addr, c_data_in, c_rd, c_wr,
        output c_data_out, c_done, c_stall, c_hit, c_err
    );

endinterface

// File: rtl/arb_rr2.sv
// arb_rr2
//   Two-way round-robin picker, purely combinational.
//   - req[1:0] : in,  request vector (bit GNT_I = fetch, bit GNT_D = data)
//   - last     : in,  requester served most recently (GNT_I / GNT_D)
//   - gnt[1:0] : out, one-hot grant, or zero when nothing requests
module arb_rr2
    import cache_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // On a tie the requester that was not served last wins.
            2'b11:   gnt = (last == GNT_I) ? 2'b10 : 2'b01;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Shares one single-ported cache controller between the instruction-fetch
//   port (read only) and the data-memory port (read/write). Requests are
//   issued one at a time with round-robin fairness; done/hit/err/data are
//   routed back to the owner, and a watchdog aborts transactions that never
//   see c_done.
//   - clk : in, clock, rising edge
//   - rst : in, asynchronous active-high reset
//   - bus : cache_arbiter_if.slave (fetch port, data port, cache port)
//   Parameters:
//   - TIMEOUT_CYCLES : busy cycles without c_done before the abort
//   - CNT_W          : watchdog width, 2**CNT_W must exceed TIMEOUT_CYCLES
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input logic            clk,
    input logic            rst,
    cache_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e       state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] wdog_q, wdog_d;

    logic             d_ill;
    logic             d_req;
    logic [1:0]       req;
    logic [1:0]       gnt;
    arb_rsp_t         rsp;
    logic             fin;

    // A simultaneous read+write on the data port is illegal and never
    // competes for the cache; only a clean read or write is a request.
    assign d_ill = bus.d_rd & bus.d_wr;
    assign d_req = bus.d_rd ^ bus.d_wr;
    assign req   = {d_req, bus.i_rd};

    arb_rr2 u_rr (
        .req  (req),
        .last (last_q),
        .gnt  (gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            last_q  <= GNT_I;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        wdog_d         = wdog_q;
        rsp            = '0;
        fin            = 1'b0;

        bus.i_data_out = '0;
        bus.i_done     = 1'b0;
        bus.i_stall    = 1'b0;
        bus.i_hit      = 1'b0;
        bus.i_err      = 1'b0;
        bus.d_data_out = '0;
        bus.d_done     = 1'b0;
        bus.d_stall    = 1'b0;
        bus.d_hit      = 1'b0;
        bus.d_err      = 1'b0;
        bus.c_addr     = '0;
        bus.c_data_in  = '0;
        bus.c_rd       = 1'b0;
        bus.c_wr       = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                wdog_d = '0;
                // The illegal data request is rejected on its own; the
                // fetch port may still be granted in the same cycle.
                if (d_ill) begin
                    bus.d_err = 1'b1;
                end
                if (bus.c_stall) begin
                    bus.i_stall = 1'b1;
                    bus.d_stall = ~d_ill;
                end else if (gnt[GNT_I]) begin
                    // Strobe goes out now so the cache samples it this edge.
                    bus.c_rd    = 1'b1;
                    bus.c_addr  = bus.i_addr;
                    bus.i_stall = 1'b1;
                    bus.d_stall = ~d_ill;
                    state_d     = ARB_BUSY_I;
                end else if (gnt[GNT_D]) begin
                    bus.c_rd      = bus.d_rd;
                    bus.c_wr      = bus.d_wr;
                    bus.c_addr    = bus.d_addr;
                    bus.c_data_in = bus.d_data_in;
                    bus.d_stall   = 1'b1;
                    bus.i_stall   = 1'b1;
                    state_d       = ARB_BUSY_D;
                end
            end

            ARB_BUSY_I, ARB_BUSY_D: begin
                wdog_d = wdog_q + 1'b1;
                // c_done wins over the watchdog when both land together.
                if (bus.c_done) begin
                    rsp.done = 1'b1;
                    rsp.hit  = bus.c_hit;
                    rsp.err  = bus.c_err;
                    rsp.data = bus.c_data_out;
                    fin      = 1'b1;
                end else if (wdog_q == WDOG_LAST) begin
                    rsp.err  = 1'b1;
                    fin      = 1'b1;
                end

                if (fin) begin
                    wdog_d  = '0;
                    state_d = ARB_IDLE;
                    last_d  = (state_q == ARB_BUSY_D) ? GNT_D : GNT_I;
                end

                // The owner's inputs keep driving the cache even if the
                // requester has already dropped its strobe.
                if (state_q == ARB_BUSY_D) begin
                    bus.c_addr     = bus.d_addr;
                    bus.c_data_in  = bus.d_data_in;
                    bus.d_done     = rsp.done;
                    bus.d_hit      = rsp.hit;
                    bus.d_err      = rsp.err;
                    bus.d_data_out = rsp.data;
                    bus.d_stall    = ~fin;
                    bus.i_stall    = 1'b1;
                end else begin
                    bus.c_addr     = bus.i_addr;
                    bus.i_done     = rsp.done;
                    bus.i_hit      = rsp.hit;
                    bus.i_err      = rsp.err;
                    bus.i_data_out = rsp.data;
                    bus.i_stall    = ~fin;
                    bus.d_stall    = 1'b1;
                end
            end

            default: begin
                // Unreachable encoding: fall back to idle quietly.
                state_d     = ARB_IDLE;
                wdog_d      = '0;
                bus.i_stall = 1'b1;
                bus.d_stall = 1'b1;
            end
        endcase

        // While reset is held nothing may pulse and both ports must wait.
        if (rst) begin
            bus.i_data_out = '0;
            bus.i_done     = 1'b0;
            bus.i_hit      = 1'b0;
            bus.i_err      = 1'b0;
            bus.d_data_out = '0;
            bus.d_done     = 1'b0;
            bus.d_hit      = 1'b0;
            bus.d_err      = 1'b0;
            bus.c_rd       = 1'b0;
            bus.c_wr       = 1'b0;
            bus.i_stall    = 1'b1;
            bus.d_stall    = 1'b1;
        end
    end

endmodule
